// File: rtl/fas_frame_drain.sv
// fas_frame_drain: output stage of the FAS pipeline.
// It captures each 16-bin FFT frame into one of two ping-pong banks and tags
// the frame with the Analysis peak index. It then streams the frame one bin
// per valid/ready handshake. A frame that arrives while both banks are busy
// is dropped and counted.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   fft_valid, fft_d0..15     frame capture (one-cycle pulse, 16 bins)
//   done, freq                Analysis result for the oldest outstanding frame
//   out_valid/out_ready       stream handshake
//   out_data/idx/last/freq    current bin word, index, last flag, frame tag
//   frame_drop, drop_cnt      drop pulse and saturating drop counter
//
// Stream FSM
//   state  | meaning
//   S_IDLE | no frame on the port; start when bank[rd_sel] is READY
//   S_SEND | out_valid high, walking idx 0..15 on handshakes
module fas_frame_drain #(
  parameter int NBINS  = 16,
  parameter int DW     = 32,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [DW-1:0]     fft_d0,
  input  logic [DW-1:0]     fft_d1,
  input  logic [DW-1:0]     fft_d2,
  input  logic [DW-1:0]     fft_d3,
  input  logic [DW-1:0]     fft_d4,
  input  logic [DW-1:0]     fft_d5,
  input  logic [DW-1:0]     fft_d6,
  input  logic [DW-1:0]     fft_d7,
  input  logic [DW-1:0]     fft_d8,
  input  logic [DW-1:0]     fft_d9,
  input  logic [DW-1:0]     fft_d10,
  input  logic [DW-1:0]     fft_d11,
  input  logic [DW-1:0]     fft_d12,
  input  logic [DW-1:0]     fft_d13,
  input  logic [DW-1:0]     fft_d14,
  input  logic [DW-1:0]     fft_d15,
  input  logic              done,
  input  logic [3:0]        freq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic [3:0]        out_freq,
  output logic              frame_drop,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {B_EMPTY, B_DATA, B_READY} bank_st_t;
  typedef enum logic {S_IDLE, S_SEND} strm_t;

  strm_t              r_state, w_state_nxt;
  bank_st_t           r_bank [2];
  logic [3:0]         r_bank_freq [2];
  logic [DW-1:0]      r_mem [2][NBINS];
  logic               r_wr_sel, r_rd_sel;
  logic [DROP_W-1:0]  r_skip, r_drop_cnt;
  logic               r_frame_drop, r_out_valid;
  logic [3:0]         r_idx, r_out_freq;

  logic [DW-1:0]      w_fft_d [NBINS];
  logic               w_start, w_hs, w_last_hs;
  logic               w_cap_free, w_capture, w_drop;
  logic               w_skip_dec, w_tag, w_tag_sel;

  assign w_fft_d = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                     fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_hs        = 1'b0;
    w_last_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bank[r_rd_sel] == B_READY) begin
          w_start     = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_hs = r_out_valid & out_ready;
        if (w_hs && r_idx == 4'd15) begin
          w_last_hs   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A bank released by the final handshake this cycle may be refilled on the same edge.
  assign w_cap_free = (r_bank[r_wr_sel] == B_EMPTY) || (w_last_hs && (r_rd_sel == r_wr_sel));
  assign w_capture  = fft_valid & w_cap_free;
  assign w_drop     = fft_valid & ~w_cap_free;

  // A done owed to a dropped frame is swallowed. Otherwise the oldest DATA bank is tagged.
  // Tagging only ever hits a DATA bank, so it never collides with the capture bank.
  assign w_skip_dec = done & (r_skip != '0);
  assign w_tag_sel  = (r_bank[r_rd_sel] == B_DATA) ? r_rd_sel : ~r_rd_sel;
  assign w_tag      = done & ~w_skip_dec & (r_bank[w_tag_sel] == B_DATA);

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NBINS; k++) r_mem[r_wr_sel][k] <= w_fft_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        r_bank[b]      <= B_EMPTY;
        r_bank_freq[b] <= 4'd0;
      end
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_skip       <= '0;
      r_drop_cnt   <= '0;
      r_frame_drop <= 1'b0;
      r_out_valid  <= 1'b0;
      r_idx        <= 4'd0;
      r_out_freq   <= 4'd0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_last_hs && r_rd_sel == 1'(b)) r_bank[b] <= B_EMPTY;
        if (w_tag && w_tag_sel == 1'(b))    r_bank[b] <= B_READY;
        if (w_capture && r_wr_sel == 1'(b)) r_bank[b] <= B_DATA;
      end
      if (w_tag) r_bank_freq[w_tag_sel] <= freq;
      if (w_capture) r_wr_sel <= ~r_wr_sel;

      r_frame_drop <= w_drop;
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;

      if (w_drop && !w_skip_dec && r_skip != '1) r_skip <= r_skip + 1'b1;
      else if (!w_drop && w_skip_dec)            r_skip <= r_skip - 1'b1;

      if (w_start) begin
        r_out_valid <= 1'b1;
        r_idx       <= 4'd0;
        r_out_freq  <= r_bank_freq[r_rd_sel];
      end else if (w_hs) begin
        if (w_last_hs) begin
          r_out_valid <= 1'b0;
          r_idx       <= 4'd0;
          r_rd_sel    <= ~r_rd_sel;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_valid ? r_mem[r_rd_sel][r_idx] : '0;
  assign out_idx    = r_idx;
  assign out_last   = r_out_valid & (r_idx == 4'd15);
  assign out_freq   = r_out_freq;
  assign frame_drop = r_frame_drop;
  assign drop_cnt   = r_drop_cnt;

endmodule
